// File: rtl/riscv_dmem_bus_bridge_pkg.sv
// riscv_dmem_bus_bridge_pkg: shared FSM encoding, load/store funct3 codes and bridge defaults.
package riscv_dmem_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    localparam logic [2:0] FUNCT3_MEM_BYTE  = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_HALF  = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_WORD  = 3'b010;
    localparam logic [2:0] FUNCT3_MEM_BYTEU = 3'b100;
    localparam logic [2:0] FUNCT3_MEM_HALFU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/riscv_dmem_align_check.sv
// riscv_dmem_align_check: flags halfword accesses on odd addresses and word accesses off a 4-byte boundary.
module riscv_dmem_align_check
    import riscv_dmem_bus_bridge_pkg::*;
(
    input  logic [2:0] func3_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o
);

    logic is_half;
    logic is_word;

    assign is_half      = (func3_i == FUNCT3_MEM_HALF) | (func3_i == FUNCT3_MEM_HALFU);
    assign is_word      = (func3_i == FUNCT3_MEM_WORD);
    assign misaligned_o = (is_half & addr_lo_i[0]) | (is_word & (|addr_lo_i));

endmodule

// File: rtl/riscv_dmem_bus_bridge.sv
// riscv_dmem_bus_bridge: MEM-stage req/gnt/rvalid bus master that stalls the pipeline
// until the access completes and reports misalignment, bus errors and timeouts.
module riscv_dmem_bus_bridge
    import riscv_dmem_bus_bridge_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mem_req,
    input  logic [XLEN-1:0]   i_mem_addr,
    input  logic [2:0]        i_mem_func3,
    input  logic              i_mem_wr_en,
    input  logic [XLEN-1:0]   i_mem_wr_data,
    input  logic [XLEN/8-1:0] i_mem_byte_sel,
    output logic              o_mem_stall,
    output logic              o_mem_done,
    output logic              o_mem_err,
    output logic [XLEN-1:0]   o_mem_rd_data,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [XLEN-1:0]   o_bus_addr,
    output logic [XLEN-1:0]   o_bus_wdata,
    output logic [XLEN/8-1:0] o_bus_be,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [XLEN-1:0]   i_bus_rdata,
    input  logic              i_bus_err
);

    bridge_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              timeout;
    logic              misaligned;
    logic              done_q;
    logic              err_q;
    logic [XLEN-1:0]   rd_data_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [XLEN-1:0]   bus_addr_q;
    logic [XLEN-1:0]   bus_wdata_q;
    logic [XLEN/8-1:0] bus_be_q;

    riscv_dmem_align_check u_align (
        .func3_i      (i_mem_func3),
        .addr_lo_i    (i_mem_addr[1:0]),
        .misaligned_o (misaligned)
    );

    assign cnt_d   = cnt_q + 1'b1;
    assign timeout = (cnt_d == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_mem_req && misaligned) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (i_mem_req) begin
                        state_q     <= ST_REQ;
                        cnt_q       <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= i_mem_wr_en;
                        bus_addr_q  <= {i_mem_addr[XLEN-1:2], 2'b00};
                        bus_wdata_q <= i_mem_wr_data;
                        bus_be_q    <= i_mem_byte_sel;
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_d;
                    // timeout wins over a same-cycle grant so an abandoned request is never tracked
                    if (timeout) begin
                        state_q   <= ST_DONE;
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else if (i_bus_gnt) begin
                        state_q   <= ST_RESP;
                        bus_req_q <= 1'b0;
                    end
                end
                ST_RESP: begin
                    cnt_q <= cnt_d;
                    if (i_bus_rvalid) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= i_bus_err;
                        if (!bus_we_q && !i_bus_err) rd_data_q <= i_bus_rdata;
                    end else if (timeout) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_stall   = i_mem_req & (state_q != ST_DONE);
    assign o_mem_done    = done_q;
    assign o_mem_err     = err_q;
    assign o_mem_rd_data = rd_data_q;
    assign o_bus_req     = bus_req_q;
    assign o_bus_we      = bus_we_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_be      = bus_be_q;

endmodule

// File: tb/tb_riscv_dmem_bus_bridge.sv
// tb_riscv_dmem_bus_bridge: table-driven transactions plus hand-written reset and
// late-response sequences for the dmem bus bridge.
module tb_riscv_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [2:0]  mem_func3;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_sel;
    logic        mem_stall;
    logic        mem_done;
    logic        mem_err;
    logic [31:0] mem_rd_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_dmem_bus_bridge dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mem_req      (mem_req),
        .i_mem_addr     (mem_addr),
        .i_mem_func3    (mem_func3),
        .i_mem_wr_en    (mem_wr_en),
        .i_mem_wr_data  (mem_wr_data),
        .i_mem_byte_sel (mem_byte_sel),
        .o_mem_stall    (mem_stall),
        .o_mem_done     (mem_done),
        .o_mem_err      (mem_err),
        .o_mem_rd_data  (mem_rd_data),
        .o_bus_req      (bus_req),
        .o_bus_we       (bus_we),
        .o_bus_addr     (bus_addr),
        .o_bus_wdata    (bus_wdata),
        .o_bus_be       (bus_be),
        .i_bus_gnt      (bus_gnt),
        .i_bus_rvalid   (bus_rvalid),
        .i_bus_rdata    (bus_rdata),
        .i_bus_err      (bus_err)
    );

    typedef struct {
        logic [2:0]  func3;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gnt_dly;
        logic [31:0] rdata;
        logic        berr;
        int          exp_lat;
        logic        exp_err;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n = 0;
        int   req_cycles = 0;
        logic gnt_given = 1'b0;
        logic rv_given = 1'b0;
        logic saw_req = 1'b0;
        logic got_done = 1'b0;
        logic stall_bad = 1'b0;
        logic bus_bad = 1'b0;
        mem_req      = 1'b1;
        mem_addr     = v.addr;
        mem_func3    = v.func3;
        mem_wr_en    = v.we;
        mem_wr_data  = v.wdata;
        mem_byte_sel = v.be;
        while (!got_done && n < 40) begin
            @(negedge clk);
            n++;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            if (mem_done) begin
                got_done = 1'b1;
            end else begin
                if (!mem_stall) stall_bad = 1'b1;
                if (gnt_given && !rv_given) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = v.rdata;
                    bus_err    = v.berr;
                    rv_given   = 1'b1;
                end else if (bus_req) begin
                    saw_req = 1'b1;
                    if (bus_addr !== v.exp_addr || bus_we !== v.we || bus_be !== v.be || bus_wdata !== v.wdata)
                        bus_bad = 1'b1;
                    if (req_cycles == v.gnt_dly) begin
                        bus_gnt   = 1'b1;
                        gnt_given = 1'b1;
                    end
                    req_cycles++;
                end
            end
        end
        chk($sformatf("v%0d done_seen", idx), {31'd0, got_done}, 32'd1);
        chk($sformatf("v%0d latency", idx), n, v.exp_lat);
        chk($sformatf("v%0d err", idx), {31'd0, mem_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d rd_data", idx), mem_rd_data, v.exp_rd);
        chk($sformatf("v%0d stall_at_done", idx), {31'd0, mem_stall}, 32'd0);
        chk($sformatf("v%0d stall_before_done", idx), {31'd0, stall_bad}, 32'd0);
        chk($sformatf("v%0d bus_issued", idx), {31'd0, saw_req}, {31'd0, v.exp_bus});
        chk($sformatf("v%0d bus_stable", idx), {31'd0, bus_bad}, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", idx), {31'd0, mem_done}, 32'd0);
        chk($sformatf("v%0d err_cleared", idx), {31'd0, mem_err}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " done"},  {31'd0, mem_done}, 32'd0);
        chk({tag, " err"},   {31'd0, mem_err}, 32'd0);
        chk({tag, " rd"},    mem_rd_data, 32'd0);
        chk({tag, " req"},   {31'd0, bus_req}, 32'd0);
        chk({tag, " we"},    {31'd0, bus_we}, 32'd0);
        chk({tag, " addr"},  bus_addr, 32'd0);
        chk({tag, " wdata"}, bus_wdata, 32'd0);
        chk({tag, " be"},    {28'd0, bus_be}, 32'd0);
        chk({tag, " stall"}, {31'd0, mem_stall}, 32'd0);
    endtask

    initial begin
        //          func3   addr          we    be       wdata         dly rdata         berr lat err bus exp_addr      exp_rd
        vecs[0] = '{3'b010, 32'h0000_0104, 1'b0, 4'b1111, 32'h0,        0,  32'hDEADBEEF, 1'b0, 3,  1'b0, 1'b1, 32'h0000_0104, 32'hDEADBEEF};
        vecs[1] = '{3'b001, 32'h0000_0202, 1'b1, 4'b1100, 32'hABCD0000, 3,  32'h11111111, 1'b0, 6,  1'b0, 1'b1, 32'h0000_0200, 32'hDEADBEEF};
        vecs[2] = '{3'b010, 32'h0000_0101, 1'b0, 4'b1111, 32'h0,        0,  32'h0,        1'b0, 1,  1'b1, 1'b0, 32'h0,         32'hDEADBEEF};
        vecs[3] = '{3'b010, 32'h0000_0300, 1'b0, 4'b1111, 32'h0,        1,  32'h55AA55AA, 1'b1, 4,  1'b1, 1'b1, 32'h0000_0300, 32'hDEADBEEF};
        vecs[4] = '{3'b000, 32'h0000_0003, 1'b0, 4'b1000, 32'h0,        0,  32'h12345678, 1'b0, 3,  1'b0, 1'b1, 32'h0000_0000, 32'h12345678};
        vecs[5] = '{3'b101, 32'h0000_0007, 1'b0, 4'b1100, 32'h0,        0,  32'h0,        1'b0, 1,  1'b1, 1'b0, 32'h0,         32'h12345678};
        vecs[6] = '{3'b001, 32'h0000_0206, 1'b1, 4'b1100, 32'h5A5A0000, 2,  32'h22222222, 1'b0, 5,  1'b0, 1'b1, 32'h0000_0204, 32'h12345678};
        vecs[7] = '{3'b010, 32'h0000_0106, 1'b0, 4'b1111, 32'h0,        0,  32'h0,        1'b0, 1,  1'b1, 1'b0, 32'h0,         32'h12345678};
        vecs[8] = '{3'b001, 32'h0000_010A, 1'b0, 4'b1100, 32'h0,        0,  32'hCAFEF00D, 1'b0, 3,  1'b0, 1'b1, 32'h0000_0108, 32'hCAFEF00D};
        vecs[9] = '{3'b010, 32'h0000_0400, 1'b0, 4'b1111, 32'h0,        99, 32'h0,        1'b0, 17, 1'b1, 1'b1, 32'h0000_0400, 32'hCAFEF00D};

        rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_func3 = '0; mem_wr_en = 1'b0;
        mem_wr_data = '0; mem_byte_sel = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        bus_rdata = '0; bus_err = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // a response arriving after the timeout must not complete anything
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rvalid done", {31'd0, mem_done}, 32'd0);
            chk("late_rvalid rd", mem_rd_data, 32'hCAFEF00D);
        end
        bus_rvalid = 1'b0;
        @(negedge clk);

        // reset while waiting in RESP
        mem_req = 1'b1; mem_addr = 32'h500; mem_func3 = 3'b010; mem_wr_en = 1'b1;
        mem_wr_data = 32'h01020304; mem_byte_sel = 4'b1111;
        @(negedge clk);
        chk("rst_seq req", {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rst_seq in_resp", {31'd0, bus_req}, 32'd0);
        chk("rst_seq stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1; mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rst_seq");
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_seq late done", {31'd0, mem_done}, 32'd0);
            chk("rst_seq late rd", mem_rd_data, 32'd0);
        end
        bus_rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
